// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields in, enables/selects and debug state out.
interface multicycle_control_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic       branch;
    logic       next_pc;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct,
        output branch, next_pc, ir_w, reg_w, mem_w, adr_src, alu_src_a,
               alu_src_b, result_src, alu_op, imm_src, reg_src, illegal, state
    );

    modport slave (
        output op, funct,
        input  branch, next_pc, ir_w, reg_w, mem_w, adr_src, alu_src_a,
               alu_src_b, result_src, alu_op, imm_src, reg_src, illegal, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore main controller for the multicycle processor: sequences fetch/decode/execute/
// memory/writeback, with a parametrised memory wait count and illegal-op detection.
module multicycle_control_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             wait_done;
    logic             wait_state;

    assign wait_done  = (cnt_q == WAIT_LAST);
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_START;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_START:    state_d = S_FETCH;
            S_FETCH:    if (wait_done) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    2'b00:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (wait_done) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (wait_done) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_START;
        endcase

        // Counter saturates at MEM_WAIT and restarts on any state change.
        if (state_d != state_q)
            cnt_d = '0;
        else if (wait_state && (cnt_q < WAIT_LAST))
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_comb begin
        bus.branch     = 1'b0;
        bus.next_pc    = 1'b0;
        bus.ir_w       = 1'b0;
        bus.reg_w      = 1'b0;
        bus.mem_w      = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.alu_op     = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_w       = wait_done;
                bus.next_pc    = wait_done;
            end
            S_DECODE: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            S_MEMADR:   bus.alu_src_b = 2'b01;
            S_MEMREAD:  bus.adr_src   = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                bus.mem_w   = wait_done;
            end
            S_EXECR:    bus.alu_op = 1'b1;
            S_EXECI: begin
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 1'b1;
            end
            S_ALUWB:    bus.reg_w = 1'b1;
            S_BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.branch     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.imm_src = bus.op;
    assign bus.reg_src = {bus.op == 2'b01, bus.op == 2'b10};
    assign bus.illegal = illegal_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: two controllers (MEM_WAIT=0 and 2) driven from a per-cycle vector table.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0] state;
        logic       branch, next_pc, ir_w, reg_w, mem_w, adr_src, alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       illegal;
    } outs_t;

    typedef struct {
        bit         sel;     // 0 = MEM_WAIT 0 instance, 1 = MEM_WAIT 2 instance
        bit         rst;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] st;
        bit         last;    // final cycle of a wait state
        bit         ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_if if0 ();
    multicycle_control_if if2 ();

    multicycle_control_fsm #(.MEM_WAIT(0), .CNT_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    multicycle_control_fsm #(.MEM_WAIT(2), .CNT_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    outs_t act0, act2;
    assign act0 = {if0.state, if0.branch, if0.next_pc, if0.ir_w, if0.reg_w, if0.mem_w,
                   if0.adr_src, if0.alu_src_a, if0.alu_src_b, if0.result_src, if0.alu_op,
                   if0.imm_src, if0.reg_src, if0.illegal};
    assign act2 = {if2.state, if2.branch, if2.next_pc, if2.ir_w, if2.reg_w, if2.mem_w,
                   if2.adr_src, if2.alu_src_a, if2.alu_src_b, if2.result_src, if2.alu_op,
                   if2.imm_src, if2.reg_src, if2.illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected Moore outputs straight from the per-state output table.
    function automatic outs_t expect_outs(input vec_t v);
        outs_t e = '0;
        e.imm_src = v.op;
        e.reg_src = {v.op == 2'b01, v.op == 2'b10};
        if (v.rst) return e;
        e.state   = v.st;
        e.illegal = v.ill;
        case (v.st)
            4'd1:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                         e.ir_w = v.last; e.next_pc = v.last; end
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
            4'd3:  e.alu_src_b = 2'b01;
            4'd4:  e.adr_src = 1;
            4'd5:  begin e.result_src = 2'b01; e.reg_w = 1; end
            4'd6:  begin e.adr_src = 1; e.mem_w = v.last; end
            4'd7:  e.alu_op = 1;
            4'd8:  begin e.alu_src_b = 2'b01; e.alu_op = 1; end
            4'd9:  e.reg_w = 1;
            4'd10: begin e.alu_src_b = 2'b01; e.result_src = 2'b10; e.branch = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t mk(input bit sel, input bit rst, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] st,
                                input bit last = 0, input bit ill = 0);
        vec_t v;
        v.sel = sel; v.rst = rst; v.op = op; v.funct = funct;
        v.st = st; v.last = last; v.ill = ill;
        return v;
    endfunction

    vec_t  vecs[$];
    outs_t sb[$];

    initial begin
        vec_t  v;
        outs_t e, a;
        int    mem_w_cnt, reg_w_cnt, ill_cnt;
        bit    seen_wr, done;

        if0.op = 2'b00; if0.funct = 6'd0;
        if2.op = 2'b00; if2.funct = 6'd0;

        // MEM_WAIT=0: R-type, I-type, branch, illegal, LDR, STR
        vecs.push_back(mk(0, 1, 2'b00, 6'h00, 0));
        vecs.push_back(mk(0, 1, 2'b00, 6'h00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 6'h00, 0));
        vecs.push_back(mk(0, 0, 2'b00, 6'h00, 1, 1));
        vecs.push_back(mk(0, 0, 2'b00, 6'h00, 2));
        vecs.push_back(mk(0, 0, 2'b00, 6'h00, 7));
        vecs.push_back(mk(0, 0, 2'b00, 6'h00, 9));
        vecs.push_back(mk(0, 0, 2'b00, 6'h20, 1, 1));
        vecs.push_back(mk(0, 0, 2'b00, 6'h20, 2));
        vecs.push_back(mk(0, 0, 2'b00, 6'h20, 8));
        vecs.push_back(mk(0, 0, 2'b00, 6'h20, 9));
        vecs.push_back(mk(0, 0, 2'b10, 6'h00, 1, 1));
        vecs.push_back(mk(0, 0, 2'b10, 6'h00, 2));
        vecs.push_back(mk(0, 0, 2'b10, 6'h00, 10));
        vecs.push_back(mk(0, 0, 2'b11, 6'h00, 1, 1));
        vecs.push_back(mk(0, 0, 2'b11, 6'h00, 2));
        vecs.push_back(mk(0, 0, 2'b01, 6'h01, 1, 1, 1));
        vecs.push_back(mk(0, 0, 2'b01, 6'h01, 2));
        vecs.push_back(mk(0, 0, 2'b01, 6'h01, 3));
        vecs.push_back(mk(0, 0, 2'b01, 6'h01, 4));
        vecs.push_back(mk(0, 0, 2'b01, 6'h01, 5));
        vecs.push_back(mk(0, 0, 2'b01, 6'h00, 1, 1));
        vecs.push_back(mk(0, 0, 2'b01, 6'h00, 2));
        vecs.push_back(mk(0, 0, 2'b01, 6'h00, 3));
        vecs.push_back(mk(0, 0, 2'b01, 6'h00, 6, 1));
        vecs.push_back(mk(0, 0, 2'b01, 6'h00, 1, 1));

        // MEM_WAIT=2: LDR, STR, then reset in the middle of a STR wait
        vecs.push_back(mk(1, 1, 2'b01, 6'h01, 0));
        vecs.push_back(mk(1, 1, 2'b01, 6'h01, 0));
        vecs.push_back(mk(1, 0, 2'b01, 6'h01, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 2'b01, 6'h01, 1, i == 2));
        vecs.push_back(mk(1, 0, 2'b01, 6'h01, 2));
        vecs.push_back(mk(1, 0, 2'b01, 6'h01, 3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 2'b01, 6'h01, 4));
        vecs.push_back(mk(1, 0, 2'b01, 6'h01, 5));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 2'b01, 6'h00, 1, i == 2));
        vecs.push_back(mk(1, 0, 2'b01, 6'h00, 2));
        vecs.push_back(mk(1, 0, 2'b01, 6'h00, 3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 2'b01, 6'h00, 6, i == 2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 2'b01, 6'h00, 1, i == 2));
        vecs.push_back(mk(1, 0, 2'b01, 6'h00, 2));
        vecs.push_back(mk(1, 0, 2'b01, 6'h00, 3));
        vecs.push_back(mk(1, 0, 2'b01, 6'h00, 6));
        vecs.push_back(mk(1, 1, 2'b01, 6'h00, 0));
        vecs.push_back(mk(1, 1, 2'b01, 6'h00, 0));
        vecs.push_back(mk(1, 0, 2'b01, 6'h00, 0));
        vecs.push_back(mk(1, 0, 2'b01, 6'h00, 1));

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            v = vecs[i];
            rst_n = !v.rst;
            if (v.sel) begin if2.op = v.op; if2.funct = v.funct; end
            else       begin if0.op = v.op; if0.funct = v.funct; end
            sb.push_back(expect_outs(v));
            @(negedge clk);
            e = sb.pop_front();
            a = v.sel ? act2 : act0;
            check($sformatf("vec%0d_w%0d_st%0d", i, v.sel ? 2 : 0, v.st), a, e);
            @(posedge clk); #1;
        end

        // Single STR at MEM_WAIT=2: exactly one mem_w, never reg_w, bounded wait.
        rst_n = 1'b0; if2.op = 2'b01; if2.funct = 6'h00;
        @(posedge clk); #1; rst_n = 1'b1;
        mem_w_cnt = 0; reg_w_cnt = 0; seen_wr = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (if2.state == 4'd6) seen_wr = 1;
            if (if2.mem_w) mem_w_cnt++;
            if (if2.reg_w) reg_w_cnt++;
            if (seen_wr && if2.state == 4'd1) done = 1;
            @(posedge clk); #1;
        end
        check("str_completes", 32'(done), 32'd1);
        check("str_mem_w_count", 32'(mem_w_cnt), 32'd1);
        check("str_reg_w_count", 32'(reg_w_cnt), 32'd0);

        // Illegal op held for 12 cycles after reset: START F D F* D F* D F* D F* D F*.
        rst_n = 1'b0; if0.op = 2'b11; if0.funct = 6'h00;
        @(posedge clk); #1; rst_n = 1'b1;
        ill_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if0.illegal) ill_cnt++;
            @(posedge clk); #1;
        end
        check("illegal_pulse_count", 32'(ill_cnt), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
